mux_sel_arbiter: RTL

Round-robin arbiter that drives the 2-bit select and grant for the team's 4:1 data multiplexer (inputs I0..I3, select S). Four sources raise requests; the arbiter picks one, holds S stable for the whole transfer, and inserts one idle release cycle between grants so the mux output never switches mid-transfer. It sits directly upstream of the mux: its S output wires straight to the mux S input.

---
 rtl/mux_sel_arbiter.sv | 89 ++++++++
 1 files changed

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the select and one-hot grant of a 4:1 data mux.
// Holds the select for the whole transfer and inserts one release cycle between grants.
module mux_sel_arbiter #(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] REQ,
    input  logic       DONE,
    output logic [1:0] S,
    output logic [3:0] GNT,
    output logic       VALID,
    output logic       TIMEOUT
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       winner;
    logic [1:0]       cand;

    // Scan from the farthest offset down so the nearest requester to ptr wins.
    always_comb begin
        winner = ptr;
        cand   = ptr;
        for (int unsigned i = 4; i > 0; i--) begin
            cand = ptr + 2'(i - 1);
            if (REQ[cand]) begin
                winner = cand;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            cnt     <= '0;
            S       <= '0;
            GNT     <= '0;
            VALID   <= 1'b0;
            TIMEOUT <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    TIMEOUT <= 1'b0;
                    if (REQ != 4'b0000) begin
                        S     <= winner;
                        GNT   <= 4'b0001 << winner;
                        VALID <= 1'b1;
                        cnt   <= CNT_ONE;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (DONE || !REQ[S] || (cnt == HOLD_LIM)) begin
                        // DONE and withdrawal take precedence over the hold limit.
                        TIMEOUT <= !DONE && REQ[S];
                        VALID   <= 1'b0;
                        GNT     <= '0;
                        ptr     <= S + 2'd1;
                        state   <= ST_RELEASE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_RELEASE: begin
                    TIMEOUT <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    TIMEOUT <= 1'b0;
                    VALID   <= 1'b0;
                    GNT     <= '0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
